// File: rtl/wb_port_pkg.sv
// Shared constants, FSM state type and write payload for the Wishbone port responder.
// Also holds the byte-lane merge helper used by every read/write register.
package wb_port_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned OFF_W   = 8;
  localparam int unsigned CHECK_W = 16;
  localparam int unsigned WAIT_W  = 4;

  localparam logic [OFF_W-1:0] OFF_CTRL    = 8'h00;
  localparam logic [OFF_W-1:0] OFF_CHECK   = 8'h04;
  localparam logic [OFF_W-1:0] OFF_COUNT   = 8'h08;
  localparam logic [OFF_W-1:0] OFF_SCRATCH = 8'h0C;
  localparam logic [OFF_W-1:0] OFF_CMP     = 8'h10;

  localparam int unsigned CTRL_CNT_EN   = 0;
  localparam int unsigned CTRL_CNT_CLR  = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;
  localparam int unsigned CTRL_IRQ_FLAG = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [OFF_W-1:0]  off;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // Replace only the byte lanes whose select bit is set.
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] cur,
                                                   input logic [DATA_W-1:0] wdata,
                                                   input logic [SEL_W-1:0]  sel);
    logic [DATA_W-1:0] res;
    res = cur;
    for (int b = 0; b < int'(SEL_W); b++) begin
      if (sel[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_port_responder_if.sv
// Wishbone classic slave-side bus bundle between the management SoC and the responder.
interface wb_port_responder_if;
  import wb_port_pkg::*;

  logic              wbs_cyc_i;
  logic              wbs_stb_i;
  logic              wbs_we_i;
  logic [SEL_W-1:0]  wbs_sel_i;
  logic [ADDR_W-1:0] wbs_adr_i;
  logic [DATA_W-1:0] wbs_dat_i;
  logic              wbs_ack_o;
  logic [DATA_W-1:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_port_regs.sv
// Register file behind the bus FSM: CTRL, CHECK, COUNT, SCRATCH, CMP plus the
// free-running counter and its compare interrupt flag.
module wb_port_regs
  import wb_port_pkg::*;
#(
  parameter logic [CHECK_W-1:0] CHECK_RESET = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  wr_req_t            wr,
  input  logic [OFF_W-1:0]   rd_off,
  output logic [DATA_W-1:0]  rd_data_c,
  output logic [CHECK_W-1:0] check,
  output logic               irq
);

  logic               cnt_en;
  logic               cnt_clr;
  logic               irq_en;
  logic               irq_flag;
  logic [CHECK_W-1:0] check_q;
  logic [DATA_W-1:0]  scratch;
  logic [DATA_W-1:0]  count;
  logic [DATA_W-1:0]  cmp;

  logic [DATA_W-1:0] count_inc;
  logic              cmp_hit;
  logic              wr_ctrl;

  assign count_inc = count + DATA_W'(1);
  assign cmp_hit   = cnt_en && !cnt_clr && (count_inc == cmp);
  assign wr_ctrl   = wr.valid && (wr.off == OFF_CTRL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_en   <= 1'b0;
      cnt_clr  <= 1'b0;
      irq_en   <= 1'b0;
      irq_flag <= 1'b0;
      check_q  <= CHECK_RESET;
      scratch  <= '0;
      count    <= '0;
      cmp      <= '1;
    end else begin
      cnt_clr <= wr_ctrl && wr.sel[0] && wr.data[CTRL_CNT_CLR];
      if (wr_ctrl && wr.sel[0]) begin
        cnt_en <= wr.data[CTRL_CNT_EN];
        irq_en <= wr.data[CTRL_IRQ_EN];
      end
      // A compare hit on the same edge as a write-1-to-clear keeps the flag set.
      if (cmp_hit) begin
        irq_flag <= 1'b1;
      end else if (wr_ctrl && wr.sel[1] && wr.data[CTRL_IRQ_FLAG]) begin
        irq_flag <= 1'b0;
      end
      if (cnt_clr) begin
        count <= '0;
      end else if (cnt_en) begin
        count <= count_inc;
      end
      if (wr.valid && (wr.off == OFF_CHECK)) begin
        check_q <= CHECK_W'(byte_merge(DATA_W'(check_q), wr.data, wr.sel));
      end
      if (wr.valid && (wr.off == OFF_SCRATCH)) begin
        scratch <= byte_merge(scratch, wr.data, wr.sel);
      end
      if (wr.valid && (wr.off == OFF_CMP)) begin
        cmp <= byte_merge(cmp, wr.data, wr.sel);
      end
    end
  end

  always_comb begin
    rd_data_c = '0;
    case (rd_off)
      OFF_CTRL: begin
        rd_data_c[CTRL_CNT_EN]   = cnt_en;
        rd_data_c[CTRL_IRQ_EN]   = irq_en;
        rd_data_c[CTRL_IRQ_FLAG] = irq_flag;
      end
      OFF_CHECK:   rd_data_c = DATA_W'(check_q);
      OFF_COUNT:   rd_data_c = count;
      OFF_SCRATCH: rd_data_c = scratch;
      OFF_CMP:     rd_data_c = cmp;
      default:     rd_data_c = '0;
    endcase
  end

  assign check = check_q;
  assign irq   = irq_flag & irq_en;

endmodule

// File: rtl/wb_port_responder.sv
// Wishbone classic slave at BASE_ADDR: IDLE/WAIT/ACK bus FSM with programmable wait
// states in front of the register file; CHECK is exported on io_out[31:16].
module wb_port_responder
  import wb_port_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  BASE_ADDR   = 32'h3000_0000,
  parameter logic [ADDR_W-1:0]  ADDR_MASK   = 32'hFFFF_FF00,
  parameter int unsigned        WAIT_STATES = 1,
  parameter logic [CHECK_W-1:0] CHECK_RESET = 16'h0000
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  wb_port_responder_if.slave   wbs,
  output logic [37:0]          io_out,
  output logic [37:0]          io_oeb,
  output logic [2:0]           user_irq
);

  state_t             state;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [OFF_W-1:0]   off_q;
  logic               we_q;
  logic               ack_q;
  logic [DATA_W-1:0]  dat_q;

  logic               req_c;
  logic               hit_c;
  logic               go_ack_c;
  logic               cur_we_c;
  logic [OFF_W-1:0]   cur_off_c;
  logic [DATA_W-1:0]  rd_data_c;
  logic [CHECK_W-1:0] check;
  logic               irq;
  wr_req_t            wr;

  assign req_c     = wbs.wbs_cyc_i && wbs.wbs_stb_i;
  assign hit_c     = (wbs.wbs_adr_i & ADDR_MASK) == BASE_ADDR;
  // In IDLE the live bus is decoded; afterwards the captured address and direction rule.
  assign cur_off_c = (state == ST_IDLE) ? wbs.wbs_adr_i[OFF_W-1:0] : off_q;
  assign cur_we_c  = (state == ST_IDLE) ? wbs.wbs_we_i : we_q;
  assign go_ack_c  = req_c && (((state == ST_IDLE) && hit_c && (WAIT_STATES == 0)) ||
                               ((state == ST_WAIT) && (wait_cnt == '0)));

  always_comb begin
    wr       = '0;
    wr.valid = go_ack_c && cur_we_c;
    wr.off   = cur_off_c;
    wr.sel   = wbs.wbs_sel_i;
    wr.data  = wbs.wbs_dat_i;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      off_q    <= '0;
      we_q     <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      ack_q <= go_ack_c;
      dat_q <= (go_ack_c && !cur_we_c) ? rd_data_c : '0;
      case (state)
        ST_IDLE: begin
          if (req_c && hit_c) begin
            off_q    <= wbs.wbs_adr_i[OFF_W-1:0];
            we_q     <= wbs.wbs_we_i;
            wait_cnt <= WAIT_W'(WAIT_STATES - 1);
            state    <= (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!req_c) begin
            state <= ST_IDLE;
          end else if (wait_cnt == '0) begin
            state <= ST_ACK;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  wb_port_regs #(
    .CHECK_RESET (CHECK_RESET)
  ) u_regs (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .wr        (wr),
    .rd_off    (cur_off_c),
    .rd_data_c (rd_data_c),
    .check     (check),
    .irq       (irq)
  );

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign io_out        = {6'h00, check, 16'h0000};
  assign io_oeb        = {6'h3F, 16'h0000, 16'hFFFF};
  assign user_irq      = {2'b00, irq};

endmodule

// File: tb/tb_wb_port_responder.sv
// Bench for wb_port_responder: three instances (1, 3 and 0 wait states) share clock and
// reset; an edge-indexed transaction model predicts every output cycle by cycle.
module tb_wb_port_responder;

  localparam int ND = 3;
  localparam logic [11:0] WS_PACK = {4'd0, 4'd3, 4'd1};
  localparam logic [47:0] CR_PACK = {16'h0000, 16'hC0DE, 16'h0000};

  logic clk = 1'b0;
  logic rst;
  logic        cyc [ND];
  logic        stb [ND];
  logic        we  [ND];
  logic [3:0]  sel [ND];
  logic [31:0] adr [ND];
  logic [31:0] wdat[ND];
  logic        ack [ND];
  logic [31:0] rdat[ND];
  logic [37:0] io_out[ND];
  logic [37:0] io_oeb[ND];
  logic [2:0]  irq [ND];

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    wb_port_responder_if bus ();
    assign bus.wbs_cyc_i = cyc[g];
    assign bus.wbs_stb_i = stb[g];
    assign bus.wbs_we_i  = we[g];
    assign bus.wbs_sel_i = sel[g];
    assign bus.wbs_adr_i = adr[g];
    assign bus.wbs_dat_i = wdat[g];
    assign ack[g]  = bus.wbs_ack_o;
    assign rdat[g] = bus.wbs_dat_o;
    wb_port_responder #(
      .BASE_ADDR   (32'h3000_0000),
      .ADDR_MASK   (32'hFFFF_FF00),
      .WAIT_STATES (32'(WS_PACK[g*4 +: 4])),
      .CHECK_RESET (CR_PACK[g*16 +: 16])
    ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wbs      (bus),
      .io_out   (io_out[g]),
      .io_oeb   (io_oeb[g]),
      .user_irq (irq[g])
    );
  end

  function automatic int ws_of(input int d);
    return 32'(WS_PACK[d*4 +: 4]);
  endfunction

  task automatic check(input string name, input int d, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%h exp=%h t=%0t", name, d, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [15:0] m_check[ND];
  bit [31:0] m_scr[ND], m_cmp[ND], m_cnt[ND];
  bit        m_en[ND], m_clr[ND], m_ien[ND], m_flag[ND];
  bit        act[ND], m_we[ND], e_ack[ND];
  bit [7:0]  m_off[ND];
  bit [31:0] e_dat[ND];
  longint    t0[ND], free_from[ND];
  longint    edge_n;

  function automatic bit [31:0] merge(input bit [31:0] cur, input bit [31:0] dt, input bit [3:0] s);
    bit [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = dt[8*b +: 8];
    return r;
  endfunction

  function automatic bit [31:0] reg_value(input int d, input bit [7:0] off);
    case (off)
      8'h00:   return {23'h0, m_flag[d], 5'h0, m_ien[d], 1'b0, m_en[d]};
      8'h04:   return {16'h0, m_check[d]};
      8'h08:   return m_cnt[d];
      8'h0C:   return m_scr[d];
      8'h10:   return m_cmp[d];
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_reset(input int d);
    m_check[d] = CR_PACK[d*16 +: 16];
    m_scr[d] = 0; m_cnt[d] = 0; m_cmp[d] = 32'hFFFF_FFFF;
    m_en[d] = 0; m_clr[d] = 0; m_ien[d] = 0; m_flag[d] = 0;
    act[d] = 0; free_from[d] = 0; e_ack[d] = 0; e_dat[d] = 0;
  endfunction

  // One clock edge for instance d: request sampled at edge t0 commits at edge t0+ws
  // provided cyc&stb stay high on every later edge up to it; ack follows in the next cycle.
  function automatic void model_step(input int d);
    bit req, commit, set_ev, nclr;
    bit [31:0] rv, nxt;
    longint ws;
    ws = longint'(ws_of(d));
    req = cyc[d] && stb[d];
    commit = 0;
    if (act[d] && edge_n > t0[d] && !req) act[d] = 0;
    if (!act[d] && edge_n >= free_from[d] && req && adr[d][31:8] == 24'h30_0000) begin
      act[d] = 1; t0[d] = edge_n; m_off[d] = adr[d][7:0]; m_we[d] = we[d];
    end
    if (act[d] && edge_n == t0[d] + ws) begin
      commit = 1; act[d] = 0; free_from[d] = edge_n + 2;
    end
    rv = reg_value(d, m_off[d]);
    e_ack[d] = commit;
    e_dat[d] = (commit && !m_we[d]) ? rv : 32'h0;
    set_ev = m_en[d] && !m_clr[d] && (m_cnt[d] + 32'd1 == m_cmp[d]);
    if (m_clr[d]) m_cnt[d] = 0;
    else if (m_en[d]) m_cnt[d] = m_cnt[d] + 32'd1;
    nclr = 0;
    if (commit && m_we[d]) begin
      case (m_off[d])
        8'h00: begin
          if (sel[d][0]) begin m_en[d] = wdat[d][0]; nclr = wdat[d][1]; m_ien[d] = wdat[d][2]; end
          if (sel[d][1] && wdat[d][8]) m_flag[d] = 0;
        end
        8'h04: begin nxt = merge({16'h0, m_check[d]}, wdat[d], sel[d]); m_check[d] = nxt[15:0]; end
        8'h0C: m_scr[d] = merge(m_scr[d], wdat[d], sel[d]);
        8'h10: m_cmp[d] = merge(m_cmp[d], wdat[d], sel[d]);
        default: ;
      endcase
    end
    m_clr[d] = nclr;
    if (set_ev) m_flag[d] = 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < ND; d++) model_reset(d);
      edge_n = 0;
    end else begin
      for (int d = 0; d < ND; d++) model_step(d);
      edge_n++;
    end
  end

  always @(negedge clk) begin
    if (started && !rst) begin
      for (int d = 0; d < ND; d++) begin
        check("ack", d, 64'(ack[d]), 64'(e_ack[d]));
        check("dat_o", d, 64'(rdat[d]), 64'(e_dat[d]));
        check("io_out", d, 64'(io_out[d]), 64'({6'h0, m_check[d], 16'h0}));
        check("io_oeb", d, 64'(io_oeb[d]), 64'({6'h3F, 16'h0, 16'hFFFF}));
        check("user_irq", d, 64'(irq[d]), 64'({2'b0, m_flag[d] & m_ien[d]}));
      end
    end
  end

  // ---------------- bus master ----------------
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] dt,
                      input logic [3:0] s, input int hold, output logic got,
                      output logic [31:0] rd, output int lat, output logic [15:0] io_hi);
    @(posedge clk); #1;
    cyc[d] = 1; stb[d] = 1; we[d] = w; adr[d] = a; wdat[d] = dt; sel[d] = s;
    got = 0; rd = 0; lat = 0; io_hi = 0;
    for (int i = 1; i <= hold && !got; i++) begin
      @(negedge clk);
      if (ack[d]) begin got = 1; lat = i; rd = rdat[d]; io_hi = io_out[d][31:16]; end
    end
    @(posedge clk); #1;
    cyc[d] = 0; stb[d] = 0; we[d] = 0;
  endtask

  task automatic do_wr(input int d, input logic [7:0] off, input logic [31:0] dt,
                       input logic [3:0] s, output logic [15:0] io_hi);
    logic g; logic [31:0] r; int l;
    xfer(d, 1'b1, 32'h3000_0000 | {24'h0, off}, dt, s, ws_of(d) + 4, g, r, l, io_hi);
    check("wr_ack", d, 64'(g), 64'd1);
  endtask

  task automatic do_rd(input int d, input logic [7:0] off, output logic [31:0] r, output int l);
    logic g; logic [15:0] h;
    xfer(d, 1'b0, 32'h3000_0000 | {24'h0, off}, 32'h0, 4'hF, ws_of(d) + 4, g, r, l, h);
    check("rd_ack", d, 64'(g), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] r;
    logic [15:0] h;
    logic        g;
    int          l;
    rst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      cyc[d] = 0; stb[d] = 0; we[d] = 0; sel[d] = 0; adr[d] = 0; wdat[d] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst = 1'b0;
    started = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      check("rst_ack", d, 64'(ack[d]), 64'd0);
      check("rst_io_out", d, 64'(io_out[d]), 64'({6'h0, CR_PACK[d*16 +: 16], 16'h0}));
      check("rst_irq", d, 64'(irq[d]), 64'd0);
    end
    do_rd(0, 8'h10, r, l); check("rst_cmp", 0, 64'(r), 64'h0000_0000_FFFF_FFFF);
    do_rd(1, 8'h04, r, l); check("rst_check", 1, 64'(r), 64'h0000_C0DE);

    // CHECK drives io_out[31:16] in the ack cycle
    do_wr(0, 8'h04, 32'h0000_AB60, 4'hF, h); check("chk_ab60", 0, 64'(h), 64'hAB60);
    check("oeb_hi", 0, 64'(io_oeb[0][31:16]), 64'd0);
    do_wr(0, 8'h04, 32'h0000_AB61, 4'hF, h); check("chk_ab61", 0, 64'(h), 64'hAB61);

    // latency: ack on the (WAIT_STATES+2)-th falling edge after the request is driven
    do_rd(1, 8'h0C, r, l); check("lat_ws3", 1, 64'(l), 64'd5);
    do_rd(2, 8'h0C, r, l); check("lat_ws0", 2, 64'(l), 64'd2);
    do_rd(0, 8'h0C, r, l); check("lat_ws1", 0, 64'(l), 64'd3);

    // byte enables
    do_wr(0, 8'h0C, 32'h0, 4'hF, h);
    do_wr(0, 8'h0C, 32'h1234_5678, 4'b0101, h);
    do_rd(0, 8'h0C, r, l); check("sel_scratch", 0, 64'(r), 64'h0034_0078);

    // counter compare interrupt, W1C, clear
    do_wr(0, 8'h00, 32'h2, 4'hF, h);
    do_wr(0, 8'h10, 32'd5, 4'hF, h);
    do_wr(0, 8'h00, 32'h5, 4'hF, h);
    g = 0;
    for (int i = 0; i < 40 && !g; i++) begin @(negedge clk); if (irq[0][0]) g = 1; end
    check("irq_rise", 0, 64'(g), 64'd1);
    do_wr(0, 8'h00, 32'h105, 4'hF, h);
    check("irq_w1c", 0, 64'(irq[0][0]), 64'd0);
    do_wr(0, 8'h00, 32'h7, 4'hF, h);
    do_rd(0, 8'h08, r, l); check("cnt_after_clr_small", 0, 64'(r <= 32'd2), 64'd1);
    do_rd(0, 8'h00, r, l); check("ctrl_clr_reads0", 0, 64'(r), 64'h105);

    // outside the window, and abort during WAIT
    xfer(0, 1'b0, 32'h3000_0100, 32'h0, 4'hF, 20, g, r, l, h); check("oow_noack", 0, 64'(g), 64'd0);
    do_wr(1, 8'h0C, 32'h1111_1111, 4'hF, h);
    xfer(1, 1'b1, 32'h3000_000C, 32'hDEAD_BEEF, 4'hF, 2, g, r, l, h); check("abort_noack", 1, 64'(g), 64'd0);
    do_rd(1, 8'h0C, r, l); check("abort_nowrite", 1, 64'(r), 64'h1111_1111);

    // randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      int d, pick, hold;
      logic [7:0] off;
      logic [31:0] a;
      d = int'($urandom_range(0, ND - 1));
      pick = int'($urandom_range(0, 7));
      case (pick)
        0: off = 8'h00; 1: off = 8'h04; 2: off = 8'h08; 3: off = 8'h0C;
        4: off = 8'h10; 5: off = 8'h14; default: off = 8'hFC;
      endcase
      a = 32'h3000_0000 | {24'h0, off};
      hold = ws_of(d) + 4;
      if (pick == 7) begin
        a = $urandom_range(0, 1) != 0 ? 32'h3000_0200 : 32'h2FFF_FF0C;
        hold = int'($urandom_range(1, 6));
      end else if ($urandom_range(0, 5) == 0) begin
        hold = int'($urandom_range(1, ws_of(d) + 1));
      end
      xfer(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), hold, g, r, l, h);
    end

    // asynchronous reset in the ack cycle of a CHECK write
    @(posedge clk); #1;
    cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = 32'h3000_0004; wdat[0] = 32'h5A5A; sel[0] = 4'hF;
    g = 0;
    for (int i = 0; i < 10 && !g; i++) begin @(negedge clk); if (ack[0]) g = 1; end
    check("rst_ack_seen", 0, 64'(g), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_ack", 0, 64'(ack[0]), 64'd0);
    check("rst_async_check", 0, 64'(io_out[0][31:16]), 64'h0);
    check("rst_async_check1", 1, 64'(io_out[1][31:16]), 64'hC0DE);
    cyc[0] = 0; stb[0] = 0; we[0] = 0;
    @(negedge clk); #2 rst = 1'b0;
    do_rd(0, 8'h04, r, l); check("rst_check_after", 0, 64'(r), 64'h0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
